// File: rtl/priority_enc_rr_v.sv
// Registered priority encoder with fixed or round-robin search start.
// Single-entry output stage with valid/ready backpressure.
module priority_enc_rr_v #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_code,
  input  logic         i_mode,
  input  logic         i_ready,
  output logic [W-1:0] o_code,
  output logic         o_valid,
  output logic [W-1:0] o_ptr
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       r_state;
  state_t       w_state_nxt;
  logic [W-1:0] r_code;
  logic [W-1:0] r_ptr;
  logic [W-1:0] w_code_nxt;
  logic [W-1:0] w_ptr_nxt;
  logic         w_accept;
  logic         w_open;
  logic         w_any;
  logic [W-1:0] w_start;
  logic [2*N-1:0] w_dbl;
  logic [N-1:0] w_rot;
  logic [W-1:0] w_off;
  logic [W-1:0] w_grant;

  assign o_valid  = (r_state == FULL);
  assign o_code   = r_code;
  assign o_ptr    = r_ptr;
  assign w_accept = o_valid & i_ready;
  assign w_open   = ~o_valid | w_accept;
  assign w_any    = |i_code;

  // Search start: 0 in fixed mode, else the pointer as it will be after this cycle.
  assign w_start = ~i_mode  ? '0 :
                   w_accept ? r_code + ONE :
                              r_ptr;

  // Rotate requests so the start index lands at bit 0.
  assign w_dbl = {i_code, i_code} >> w_start;
  assign w_rot = w_dbl[N-1:0];

  // Lowest set bit of the rotated request vector.
  always_comb begin
    w_off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = W'(i);
    end
  end

  assign w_grant = w_start + w_off;

  // Next-state, code and pointer selection.
  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    w_ptr_nxt   = r_ptr;
    if (w_open) begin
      if (w_any) begin
        w_state_nxt = FULL;
        w_code_nxt  = w_grant;
      end else begin
        w_state_nxt = EMPTY;
        w_code_nxt  = '0;
      end
    end
    if (!i_mode) begin
      w_ptr_nxt = '0;
    end else if (w_accept) begin
      w_ptr_nxt = r_code + ONE;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= EMPTY;
      r_code  <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_code_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

endmodule
